// File: rtl/lint_rr_arbiter.sv
// lint_rr_arbiter: N-channel arbiter feeding a single one-word output buffer.
// The winner is chosen combinationally from in_valid: round-robin after the
// last granted channel (MODE 0) or lowest index first (MODE 1). The buffer
// refills in the same cycle it drains, so a continuously ready consumer sees
// one word per clock. grant_cnt counts accepted input transfers and
// saturates at its maximum value.
module lint_rr_arbiter #(
    parameter int NCH  = 4,
    parameter int W    = 8,
    parameter int MODE = 0,
    parameter int CW   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NCH-1:0]           in_valid,
    input  logic [NCH*W-1:0]         in_data,
    output logic [NCH-1:0]           in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(NCH)-1:0]   out_chan,
    output logic [CW-1:0]            grant_cnt
);

    localparam int LW = $clog2(NCH);

    // Registered state
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_data_q,  out_data_d;
    logic [LW-1:0] out_chan_q,  out_chan_d;
    logic [LW-1:0] ptr_q,       ptr_d;
    logic [CW-1:0] grant_q,     grant_d;

    // Arbitration signals
    logic [W-1:0]  ch_data [NCH];
    logic [LW-1:0] win_rr;
    logic [LW-1:0] win_fp;
    logic [LW-1:0] win;
    logic          space;
    logic          arb_en;
    logic          in_xfer;
    logic          out_xfer;

    // Unpack the flat data bus into one word per channel.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign ch_data[gi] = in_data[gi*W +: W];
        end
    endgenerate

    // Round-robin search: first requester after ptr, wrapping around.
    always_comb begin
        int   idx;
        logic found;
        win_rr = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (!found && in_valid[idx]) begin
                win_rr = LW'(idx);
                found  = 1'b1;
            end
        end
    end

    // Fixed-priority search: scan downward so the lowest index wins last.
    always_comb begin
        win_fp = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (in_valid[k]) begin
                win_fp = LW'(k);
            end
        end
    end

    assign win = (MODE == 1) ? win_fp : win_rr;

    // Buffer can take a word when empty or draining this cycle; arbitration is
    // additionally gated by reset so nothing is offered while rst_n is low.
    assign space    = ~out_valid_q | out_ready;
    assign arb_en   = rst_n & space & (|in_valid);
    assign out_xfer = out_valid_q & out_ready;

    // One-hot ready towards the winning channel only.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ready
            assign in_ready[gi] = arb_en & (win == LW'(gi));
        end
    endgenerate

    assign in_xfer = |(in_valid & in_ready);

    // Next-state: load on input transfer, otherwise drain or hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[win];
            out_chan_d  = win;
            ptr_d       = win;
            if (grant_q != {CW{1'b1}}) begin
                grant_d = grant_q + 1'b1;
            end
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // State register; ptr resets to the last channel so channel 0 goes first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            ptr_q       <= LW'(NCH - 1);
            grant_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign grant_cnt = grant_q;

endmodule

// File: tb/tb_lint_rr_arbiter.sv
// Directed bench for lint_rr_arbiter. Three instances share the stimulus:
// u0 round-robin (CW=16), u1 fixed priority, u2 round-robin with CW=3.
module tb_lint_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic [3:0]  r0_ready, r1_ready, r2_ready;
    logic        r0_valid, r1_valid, r2_valid;
    logic [7:0]  r0_data, r1_data, r2_data;
    logic [1:0]  r0_chan, r1_chan, r2_chan;
    logic [15:0] r0_cnt, r1_cnt;
    logic [2:0]  r2_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lint_rr_arbiter #(.NCH(4), .W(8), .MODE(0), .CW(16)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r0_ready), .out_valid(r0_valid), .out_ready(out_ready),
        .out_data(r0_data), .out_chan(r0_chan), .grant_cnt(r0_cnt));

    lint_rr_arbiter #(.NCH(4), .W(8), .MODE(1), .CW(16)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r1_ready), .out_valid(r1_valid), .out_ready(out_ready),
        .out_data(r1_data), .out_chan(r1_chan), .grant_cnt(r1_cnt));

    lint_rr_arbiter #(.NCH(4), .W(8), .MODE(0), .CW(3)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(r2_ready), .out_valid(r2_valid), .out_ready(out_ready),
        .out_data(r2_data), .out_chan(r2_chan), .grant_cnt(r2_cnt));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- Reset with all channels requesting ----
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 32'hA3A2A1A0;
        out_ready = 1'b0;
        cyc();
        cyc();
        check("rst_valid", 64'(r0_valid), 64'd0);
        check("rst_ready", 64'(r0_ready), 64'b0000);
        check("rst_cnt",   64'(r0_cnt),   64'd0);
        check("rst_data",  64'(r0_data),  64'h00);
        rst_n = 1'b1;
        #1;
        check("rel_ready", 64'(r0_ready), 64'b0001);

        // ---- Round-robin rotation, consumer always ready ----
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("rr_ready", 64'(r0_ready), 64'(4'b0001 << (i % 4)));
            cyc();
            $display("rr step %0d: chan=%0d data=%0h valid=%0b", i, r0_chan, r0_data, r0_valid);
            check("rr_valid", 64'(r0_valid), 64'd1);
            check("rr_chan",  64'(r0_chan),  64'(i % 4));
            check("rr_data",  64'(r0_data),  64'(8'hA0 + 8'(i % 4)));
        end
        check("rr_cnt", 64'(r0_cnt), 64'd5);

        // ---- Backpressure after a single transfer from ch2 ----
        in_valid = 4'b0100;
        in_data  = 32'hA35CA1A0;
        #1;
        check("bp_ready2", 64'(r0_ready), 64'b0100);
        cyc();
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_hold_ready", 64'(r0_ready), 64'b0000);
            check("bp_hold_valid", 64'(r0_valid), 64'd1);
            check("bp_hold_data",  64'(r0_data),  64'h5C);
            cyc();
        end
        check("bp_hold_chan", 64'(r0_chan), 64'd2);
        out_ready = 1'b1;
        #1;
        check("bp_rel_ready", 64'(r0_ready), 64'b1000);
        cyc();
        $display("bp release: chan=%0d data=%0h", r0_chan, r0_data);
        check("bp_rel_chan", 64'(r0_chan), 64'd3);
        check("bp_rel_data", 64'(r0_data), 64'hA3);
        check("bp_cnt",      64'(r0_cnt),  64'd7);

        // ---- Reset asserted while a word is stalled ----
        out_ready = 1'b0;
        #1;
        check("mid_stall_ready", 64'(r0_ready), 64'b0000);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(r0_valid), 64'd0);
        check("mid_rst_data",  64'(r0_data),  64'h00);
        check("mid_rst_cnt",   64'(r0_cnt),   64'd0);
        check("mid_rst_ready", 64'(r0_ready), 64'b0000);
        cyc();
        check("mid_rst_hold", 64'(r0_valid), 64'd0);
        rst_n = 1'b1;
        in_data = 32'hA3A2A1A0;
        #1;
        check("mid_rel_ready", 64'(r0_ready), 64'b0001);
        out_ready = 1'b1;
        cyc();
        $display("post-reset grant: chan=%0d data=%0h", r0_chan, r0_data);
        check("mid_rel_chan", 64'(r0_chan), 64'd0);
        check("mid_rel_data", 64'(r0_data), 64'hA0);

        // ---- Drain with no new request: valid clears, word held ----
        in_valid = 4'b0000;
        #1;
        check("idle_ready", 64'(r0_ready), 64'b0000);
        cyc();
        check("idle_valid", 64'(r0_valid), 64'd0);
        check("idle_data",  64'(r0_data),  64'hA0);
        check("idle_chan",  64'(r0_chan),  64'd0);

        // ---- Fixed priority (u1) ----
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fp_ready_1010", 64'(r1_ready), 64'b0010);
            cyc();
            $display("fp 1010 step %0d: chan=%0d", i, r1_chan);
            check("fp_chan_1010", 64'(r1_chan), 64'd1);
            check("fp_data_1010", 64'(r1_data), 64'hA1);
        end
        in_valid = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fp_ready_1011", 64'(r1_ready), 64'b0001);
            cyc();
            $display("fp 1011 step %0d: chan=%0d", i, r1_chan);
            check("fp_chan_1011", 64'(r1_chan), 64'd0);
        end
        in_valid = 4'b1000;
        #1;
        check("fp_ready_1000", 64'(r1_ready), 64'b1000);
        cyc();
        $display("fp 1000: chan=%0d data=%0h", r1_chan, r1_data);
        check("fp_chan_1000", 64'(r1_chan), 64'd3);
        check("fp_data_1000", 64'(r1_data), 64'hA3);

        // ---- Saturation of the 3-bit counter (u2) ----
        rst_n = 1'b0;
        #1;
        check("sat_rst_cnt", 64'(r2_cnt), 64'd0);
        cyc();
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            $display("sat step %0d: cnt3=%0d cnt16=%0d", i, r2_cnt, r0_cnt);
            check("sat_cnt", 64'(r2_cnt), 64'((i > 7) ? 7 : i));
        end
        check("sat_wide_cnt", 64'(r0_cnt), 64'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
